// File: rtl/mul_pkg.sv
// Shared constants, rank payload type and operand-half extension helper for mul_pipe_nxn.
package mul_pkg;
    localparam int MUL_MAX_WIDTH  = 64;
    localparam int MUL_MAX_STAGES = 4;
    localparam int MUL_HALF_MAX   = MUL_MAX_WIDTH / 2;
    localparam int MUL_PROD_MAX   = 2 * MUL_MAX_WIDTH;

    typedef struct packed {
        logic                    valid;
        logic                    simd;
        logic [MUL_PROD_MAX-1:0] product;
    } mul_rank_t;

    // Widens an hw-bit half (zero-padded in 'half') by one bit, filled with its sign when sgn=1.
    function automatic logic [MUL_HALF_MAX:0] ext_half(input logic [MUL_HALF_MAX-1:0] half,
                                                       input int hw, input logic sgn);
        logic [MUL_HALF_MAX:0] mask;
        logic                  fill;
        mask = {(MUL_HALF_MAX+1){1'b1}} << hw;
        fill = sgn & (|(half & (MUL_HALF_MAX'(1) << (hw - 1))));
        return fill ? ({1'b0, half} | mask) : {1'b0, half};
    endfunction
endpackage

// File: rtl/mul_half_q.sv
// One signed (W)x(W) quadrant multiplier; operands arrive already sign/zero-extended by one bit.
module mul_half_q #(
    parameter int W = 17
) (
    input  logic signed [W-1:0]   a,
    input  logic signed [W-1:0]   b,
    output logic signed [2*W-1:0] p
);
    assign p = a * b;
endmodule

// File: rtl/mul_pipe_nxn.sv
// Pipelined NxN multiplier with per-operand signedness, two-lane SIMD mode and stall/flush control.
// Define MUL_PIPE_PERF_CNT_EN to add the perf_ops / perf_flushed counters.
module mul_pipe_nxn
    import mul_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic               simd,
    input  logic               sign1,
    input  logic               sign2,
    input  logic [WIDTH-1:0]   src1,
    input  logic [WIDTH-1:0]   src2,
    output logic               out_valid,
    output logic               out_simd,
    output logic [2*WIDTH-1:0] dst
`ifdef MUL_PIPE_PERF_CNT_EN
    ,
    output logic [31:0]        perf_ops,
    output logic [31:0]        perf_flushed
`endif
);
    localparam int H  = WIDTH / 2;
    localparam int HX = H + 1;
    localparam int QW = 2 * HX;
    localparam int PW = 2 * WIDTH;
    localparam int QD = (STAGES > 1) ? STAGES - 1 : 1;

    logic          accept;
    logic [HX-1:0] a_h, a_l, b_h, b_l, a_hx, a_lx;
    logic [QW-1:0] q_hh_c, q_hl_c, q_lh_c, q_ll_c;
    logic [QW-1:0] f_hh, f_hl, f_lh, f_ll;
    logic          f_valid, f_simd;
    logic [QD-1:0] q_valid;
    logic [PW-1:0] hh_x, hl_x, lh_x, ll_x, full_p, f_prod;
    mul_rank_t     rank_q;
    logic          unused_rank;

    assign accept = in_valid & ~stall & ~flush;

    // Full mode treats the low halves as unsigned digits; in SIMD each half is its own signed lane.
    assign a_h = HX'(ext_half(MUL_HALF_MAX'(src1[WIDTH-1:H]), H, sign1));
    assign b_h = HX'(ext_half(MUL_HALF_MAX'(src2[WIDTH-1:H]), H, sign2));
    assign a_l = HX'(ext_half(MUL_HALF_MAX'(src1[H-1:0]), H, sign1 & simd));
    assign b_l = HX'(ext_half(MUL_HALF_MAX'(src2[H-1:0]), H, sign2 & simd));
    assign a_hx = simd ? '0 : a_h;
    assign a_lx = simd ? '0 : a_l;

    mul_half_q #(.W(HX)) u_q_hh (.a(a_h),  .b(b_h), .p(q_hh_c));
    mul_half_q #(.W(HX)) u_q_hl (.a(a_hx), .b(b_l), .p(q_hl_c));
    mul_half_q #(.W(HX)) u_q_lh (.a(a_lx), .b(b_h), .p(q_lh_c));
    mul_half_q #(.W(HX)) u_q_ll (.a(a_l),  .b(b_l), .p(q_ll_c));

    generate
        if (STAGES == 1) begin : g_comb
            assign f_valid = accept;
            assign f_simd  = simd;
            assign f_hh    = q_hh_c;
            assign f_hl    = q_hl_c;
            assign f_lh    = q_lh_c;
            assign f_ll    = q_ll_c;
            assign q_valid = '0;
        end else begin : g_quad
            logic [QW-1:0] hh_r [QD];
            logic [QW-1:0] hl_r [QD];
            logic [QW-1:0] lh_r [QD];
            logic [QW-1:0] ll_r [QD];
            logic [QD-1:0] simd_r;

            // Rank 1 captures the quadrant products; any further ranks before the adder just delay them.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_valid <= '0;
                    simd_r  <= '0;
                    for (int i = 0; i < QD; i++) begin
                        hh_r[i] <= '0;
                        hl_r[i] <= '0;
                        lh_r[i] <= '0;
                        ll_r[i] <= '0;
                    end
                end else begin
                    if (!stall) begin
                        q_valid[0] <= accept;
                        simd_r[0]  <= simd;
                        hh_r[0]    <= q_hh_c;
                        hl_r[0]    <= q_hl_c;
                        lh_r[0]    <= q_lh_c;
                        ll_r[0]    <= q_ll_c;
                        for (int i = 1; i < QD; i++) begin
                            q_valid[i] <= q_valid[i-1];
                            simd_r[i]  <= simd_r[i-1];
                            hh_r[i]    <= hh_r[i-1];
                            hl_r[i]    <= hl_r[i-1];
                            lh_r[i]    <= lh_r[i-1];
                            ll_r[i]    <= ll_r[i-1];
                        end
                    end
                    if (flush) q_valid <= '0;
                end
            end

            assign f_valid = q_valid[QD-1];
            assign f_simd  = simd_r[QD-1];
            assign f_hh    = hh_r[QD-1];
            assign f_hl    = hl_r[QD-1];
            assign f_lh    = lh_r[QD-1];
            assign f_ll    = ll_r[QD-1];
        end
    endgenerate

    assign hh_x   = {{(PW-QW){f_hh[QW-1]}}, f_hh};
    assign hl_x   = {{(PW-QW){f_hl[QW-1]}}, f_hl};
    assign lh_x   = {{(PW-QW){f_lh[QW-1]}}, f_lh};
    assign ll_x   = {{(PW-QW){f_ll[QW-1]}}, f_ll};
    assign full_p = (hh_x << WIDTH) + ((hl_x + lh_x) << H) + ll_x;
    assign f_prod = f_simd ? {f_hh[WIDTH-1:0], f_ll[WIDTH-1:0]} : full_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rank_q <= '0;
        end else begin
            if (!stall) begin
                rank_q.valid   <= f_valid;
                rank_q.simd    <= f_simd;
                rank_q.product <= MUL_PROD_MAX'(f_prod);
            end
            if (flush) rank_q.valid <= 1'b0;
        end
    end

    assign out_valid   = rank_q.valid;
    assign out_simd    = rank_q.simd;
    assign dst         = rank_q.product[PW-1:0];
    assign unused_rank = ^rank_q.product;

`ifdef MUL_PIPE_PERF_CNT_EN
    // Counters ignore stall so they reflect raw issue and kill activity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops     <= '0;
            perf_flushed <= '0;
        end else begin
            if (accept) perf_ops <= perf_ops + 32'd1;
            if (flush)  perf_flushed <= perf_flushed + 32'($countones({rank_q.valid, q_valid}));
        end
    end
`endif
endmodule
